sevenseg_mux_driver: RTL

//   Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display.

---
 rtl/sevenseg_pkg.sv | 51 +++++
 rtl/sevenseg_mux_driver_if.sv | 32 +++
 rtl/sevenseg_slot_timer.sv | 65 ++++++
 rtl/sevenseg_mux_driver.sv | 92 +++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_pkg
// Description : Shared helpers for the seven-segment display path: pin
//               polarity levels, refresh-period clamp and hex glyphs.
// Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    localparam int unsigned c_min_period = 2;

    // Level that leaves a segment dark for the given pin polarity.
    function automatic logic seg_off(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    function automatic logic an_off(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    function automatic int unsigned clamp_period(input int unsigned p);
        return (p < c_min_period) ? c_min_period : p;
    endfunction

    // Segment order {g,f,e,d,c,b,a}, 1 = lit.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        g = 7'h00;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_mux_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_mux_driver_if
// Description : Encoder-to-driver bundle: digit patterns and scan controls
//               in, board pin levels out.
// Revision    : 1.0 - initial release
// ============================================================================
interface sevenseg_mux_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_WIDTH  = 7,
    parameter int DIV_WIDTH  = 12
);
    logic                             en;
    logic [NUM_DIGITS*SEG_WIDTH-1:0]  digits_flat;
    logic [NUM_DIGITS-1:0]            blank_mask;
    logic [DIV_WIDTH-1:0]             period;
    logic [DIV_WIDTH-1:0]             on_time;
    logic [SEG_WIDTH-1:0]             segments;
    logic [NUM_DIGITS-1:0]            anodes;
    logic                             frame_start;

    modport master (
        output en, digits_flat, blank_mask, period, on_time,
        input  segments, anodes, frame_start
    );

    modport slave (
        input  en, digits_flat, blank_mask, period, on_time,
        output segments, anodes, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/sevenseg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_slot_timer
// Description : Per-digit slot counter and digit index with wrap and
//               frame-pending indication.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_slot_timer
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [DIV_WIDTH-1:0]          i_period,
    output logic [DIV_WIDTH-1:0]          o_cnt,
    output logic [$clog2(NUM_DIGITS)-1:0] o_idx,
    output logic [$clog2(NUM_DIGITS)-1:0] o_next_idx,
    output logic                          o_wrap,
    output logic                          o_frame_pend
);
    localparam int IDX_WIDTH = $clog2(NUM_DIGITS);
    localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [IDX_WIDTH-1:0] r_idx;
    logic                 r_frame_pend;
    logic [DIV_WIDTH-1:0] w_period_eff;
    logic [IDX_WIDTH-1:0] w_next_idx;
    logic                 w_wrap;

    assign w_period_eff = DIV_WIDTH'(clamp_period(32'(i_period)));
    // >= rather than == so a period shrunk below the current count ends the slot at once.
    assign w_wrap       = i_en && (r_cnt >= (w_period_eff - DIV_WIDTH'(1)));
    assign w_next_idx   = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_pend <= 1'b0;
        end else if (!i_en) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_pend <= 1'b0;
        end else if (w_wrap) begin
            r_cnt        <= '0;
            r_idx        <= w_next_idx;
            r_frame_pend <= (r_idx == c_last_idx);
        end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_frame_pend <= 1'b0;
        end
    end

    assign o_cnt        = r_cnt;
    assign o_idx        = r_idx;
    assign o_next_idx   = w_next_idx;
    assign o_wrap       = w_wrap;
    assign o_frame_pend = r_frame_pend;

endmodule
`default_nettype wire

// File: rtl/sevenseg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_mux_driver
// Description : Time-multiplexed N-digit seven-segment driver with brightness,
//               guard interval, blanking, pin polarity and frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_mux_driver
    import sevenseg_pkg::*;
#(
    parameter int          NUM_DIGITS     = 4,
    parameter int          SEG_WIDTH      = 7,
    parameter int          DIV_WIDTH      = 12,
    parameter int unsigned GUARD          = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sevenseg_mux_driver_if.slave bus
);
    localparam int IDX_WIDTH = $clog2(NUM_DIGITS);

    logic [DIV_WIDTH-1:0]  w_cnt;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic [IDX_WIDTH-1:0]  w_next_idx;
    logic                  w_wrap;
    logic                  w_frame_pend;
    logic [SEG_WIDTH-1:0]  w_digits [NUM_DIGITS];
    logic                  w_sel;
    logic [NUM_DIGITS-1:0] w_an_onehot;

    logic [SEG_WIDTH-1:0]  r_seg_q;
    logic [SEG_WIDTH-1:0]  r_seg_raw;
    logic [NUM_DIGITS-1:0] r_an_raw;
    logic                  r_frame;

    sevenseg_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIV_WIDTH  (DIV_WIDTH)
    ) u_slot_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (bus.en),
        .i_period     (bus.period),
        .o_cnt        (w_cnt),
        .o_idx        (w_idx),
        .o_next_idx   (w_next_idx),
        .o_wrap       (w_wrap),
        .o_frame_pend (w_frame_pend)
    );

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
            assign w_digits[gi] = bus.digits_flat[gi*SEG_WIDTH +: SEG_WIDTH];
        end
    endgenerate

    // Pattern is latched once per slot so encoder updates never tear a digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_q <= '0;
        end else if (!bus.en) begin
            r_seg_q <= w_digits[0];
        end else if (w_wrap) begin
            r_seg_q <= w_digits[w_next_idx];
        end
    end

    assign w_sel = bus.en && !bus.blank_mask[w_idx]
                && (w_cnt >= DIV_WIDTH'(GUARD)) && (w_cnt < bus.on_time);
    assign w_an_onehot = w_sel ? (NUM_DIGITS'(1) << w_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_raw  <= '0;
            r_seg_raw <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_an_raw  <= w_an_onehot;
            r_seg_raw <= w_sel ? r_seg_q : '0;
            r_frame   <= bus.en && w_frame_pend;
        end
    end

    // Raw registers are active-high; XOR with the off level gives pin polarity.
    assign bus.anodes      = r_an_raw  ^ {NUM_DIGITS{an_off(AN_ACTIVE_LOW)}};
    assign bus.segments    = r_seg_raw ^ {SEG_WIDTH{seg_off(SEG_ACTIVE_LOW)}};
    assign bus.frame_start = r_frame;

endmodule
`default_nettype wire
